// File: rtl/clause_array_unloader.sv
// clause_array_unloader: walks every slot of a clause_array, skips empty
// slots (length 0) and streams each non-empty clause out over a
// valid/ready handshake, then pulses done_o.
module clause_array_unloader #(
   parameter int NUM_CLAUSES = 8,
   parameter int NUM_VARS    = 8,
   parameter int WIDTH_C_LEN = 4,
   localparam int IW         = $clog2(NUM_CLAUSES),
   localparam int CW         = IW + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [NUM_CLAUSES-1:0]   rd_o,
   input  logic [NUM_VARS*3-1:0]    var_value_i,
   input  logic [WIDTH_C_LEN:0]     clause_len_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [IW-1:0]            out_index_o,
   output logic [NUM_VARS*3-1:0]    out_var_value_o,
   output logic [WIDTH_C_LEN:0]     out_clause_len_o,
   output logic [CW-1:0]            count_o
);

   typedef enum logic [1:0] {IDLE, SEL, OUT, DONE} state_t;

   state_t        state;
   logic [IW-1:0] idx;
   logic          last;
   logic [IW-1:0] idx_nxt;

   // one-hot read select for a given slot
   function automatic logic [NUM_CLAUSES-1:0] sel(input logic [IW-1:0] i);
      logic [NUM_CLAUSES-1:0] one;
      one = {{(NUM_CLAUSES-1){1'b0}}, 1'b1};
      return one << i;
   endfunction

   assign last    = (idx == IW'(NUM_CLAUSES - 1));
   assign idx_nxt = idx + IW'(1);

   // control FSM; all outputs are registered alongside the state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         idx              <= '0;
         busy_o           <= 1'b0;
         done_o           <= 1'b0;
         rd_o             <= '0;
         out_valid_o      <= 1'b0;
         out_index_o      <= '0;
         out_var_value_o  <= '0;
         out_clause_len_o <= '0;
         count_o          <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  idx     <= '0;
                  count_o <= '0;
                  busy_o  <= 1'b1;
                  rd_o    <= sel('0);
                  state   <= SEL;
               end
            end
            SEL: begin
               if (clause_len_i != '0) begin
                  out_index_o      <= idx;
                  out_var_value_o  <= var_value_i;
                  out_clause_len_o <= clause_len_i;
                  out_valid_o      <= 1'b1;
                  rd_o             <= '0;
                  state            <= OUT;
               end else if (last) begin
                  // empty final slot: nothing left to present
                  rd_o   <= '0;
                  done_o <= 1'b1;
                  state  <= DONE;
               end else begin
                  idx   <= idx_nxt;
                  rd_o  <= sel(idx_nxt);
               end
            end
            OUT: begin
               // out_* hold until the downstream accepts
               if (out_ready_i) begin
                  count_o     <= count_o + CW'(1);
                  out_valid_o <= 1'b0;
                  if (last) begin
                     done_o <= 1'b1;
                     state  <= DONE;
                  end else begin
                     idx   <= idx_nxt;
                     rd_o  <= sel(idx_nxt);
                     state <= SEL;
                  end
               end
            end
            DONE: begin
               done_o <= 1'b0;
               busy_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
